// File: rtl/sha256_msg_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module : sha256_msg_loader_pkg
// Brief  : Shared constants, FSM states and last-word marking for the loader.
// Rev    : 1.0
// ============================================================================
package sha256_msg_loader_pkg;

  localparam int WORD_W             = 32;
  localparam int SHA256_BLOCK_WORDS = 16;
  localparam int SHA256_LEN_WORD_HI = 14;
  localparam logic [WORD_W-1:0] PAD_MARKER = 32'h8000_0000;

  typedef enum logic [2:0] {
    ST_LOAD   = 3'd0,
    ST_PAD    = 3'd1,
    ST_LEN_HI = 3'd2,
    ST_LEN_LO = 3'd3,
    ST_START  = 3'd4,
    ST_WAIT   = 3'd5,
    ST_ERR    = 3'd6
  } state_t;

  // Keep the first i_nbytes bytes of the final word and append the 0x80 marker.
  function automatic logic [WORD_W-1:0] mark_last_word(
    input logic [WORD_W-1:0] i_word,
    input logic [2:0]        i_nbytes
  );
    logic [WORD_W-1:0] w_out;
    case (i_nbytes)
      3'd0:    w_out = PAD_MARKER;
      3'd1:    w_out = {i_word[31:24], 24'h80_0000};
      3'd2:    w_out = {i_word[31:16], 16'h8000};
      3'd3:    w_out = {i_word[31:8], 8'h80};
      default: w_out = i_word;
    endcase
    return w_out;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sha256_word_buf.sv
`default_nettype none
// ============================================================================
// Module : sha256_word_buf
// Brief  : Word RAM, one synchronous write port, one asynchronous read port.
// Rev    : 1.0
// ============================================================================
module sha256_word_buf #(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [31:0]       i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [31:0]       o_rdata
);

  logic [31:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/sha256_msg_loader.sv
`default_nettype none
// ============================================================================
// Module : sha256_msg_loader
// Brief  : Accepts a big-endian word stream, applies SHA-256 padding into a
//          block buffer, then hands the buffer to sha256_update until done.
// Rev    : 1.0
// ============================================================================
module sha256_msg_loader
  import sha256_msg_loader_pkg::*;
#(
  parameter int NUM_BLOCKS = 2,
  parameter int ADDR_W     = $clog2(16*NUM_BLOCKS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       in_data,
  input  logic              in_valid,
  input  logic              in_last,
  input  logic [2:0]        in_nbytes,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [31:0]       w,
  output logic [63:0]       msg_size,
  output logic [ADDR_W-4:0] num_blocks,
  output logic              update,
  input  logic              done,
  output logic              busy,
  output logic              err
);

  localparam int c_depth   = SHA256_BLOCK_WORDS * NUM_BLOCKS;
  localparam int c_wp_w    = ADDR_W + 1;
  localparam int c_bytes_w = ADDR_W + 3;

  state_t                 r_state, w_state_nxt;
  logic [c_wp_w-1:0]      r_wp, w_wp_nxt, w_wp_inc;
  logic [c_bytes_w-1:0]   r_bytes, w_bytes_nxt;
  logic                   r_mark_placed, w_mark_nxt;
  logic [63:0]            r_msg_size, w_msg_size_nxt;
  logic [ADDR_W-4:0]      r_num_blocks, w_num_blocks_nxt;
  logic                   r_err, w_err_nxt;

  logic                   w_we;
  logic [31:0]            w_wdata;
  logic                   w_full;
  logic [2:0]             w_last_nbytes;
  logic [63:0]            w_bitlen;

  // wp is one bit wider than the RAM address so a full buffer is detectable.
  assign w_wp_inc      = r_wp + c_wp_w'(1);
  assign w_full        = (r_wp == c_wp_w'(c_depth));
  assign w_last_nbytes = (in_nbytes > 3'd4) ? 3'd4 : in_nbytes;
  assign w_bitlen      = {{(64-c_bytes_w-3){1'b0}}, r_bytes, 3'b000};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= ST_LOAD;
      r_wp          <= '0;
      r_bytes       <= '0;
      r_mark_placed <= 1'b0;
      r_msg_size    <= '0;
      r_num_blocks  <= '0;
      r_err         <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_wp          <= w_wp_nxt;
      r_bytes       <= w_bytes_nxt;
      r_mark_placed <= w_mark_nxt;
      r_msg_size    <= w_msg_size_nxt;
      r_num_blocks  <= w_num_blocks_nxt;
      r_err         <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_wp_nxt         = r_wp;
    w_bytes_nxt      = r_bytes;
    w_mark_nxt       = r_mark_placed;
    w_msg_size_nxt   = r_msg_size;
    w_num_blocks_nxt = r_num_blocks;
    w_err_nxt        = r_err;
    w_we             = 1'b0;
    w_wdata          = '0;

    case (r_state)
      ST_LOAD: begin
        if (in_valid) begin
          if (w_full) begin
            w_err_nxt   = 1'b1;
            w_state_nxt = ST_ERR;
          end else begin
            w_we     = 1'b1;
            w_wp_nxt = w_wp_inc;
            if (in_last) begin
              w_wdata     = mark_last_word(in_data, w_last_nbytes);
              w_bytes_nxt = r_bytes + c_bytes_w'(w_last_nbytes);
              w_mark_nxt  = (w_last_nbytes != 3'd4);
              w_state_nxt = ST_PAD;
            end else begin
              w_wdata     = in_data;
              w_bytes_nxt = r_bytes + c_bytes_w'(4);
            end
          end
        end
      end

      ST_PAD: begin
        if (r_mark_placed && (r_wp[3:0] == 4'(SHA256_LEN_WORD_HI))) begin
          w_state_nxt = ST_LEN_HI;
        end else if (w_full) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = ST_ERR;
        end else begin
          w_we       = 1'b1;
          w_wdata    = r_mark_placed ? 32'h0 : PAD_MARKER;
          w_mark_nxt = 1'b1;
          w_wp_nxt   = w_wp_inc;
        end
      end

      ST_LEN_HI: begin
        if (w_full) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = ST_ERR;
        end else begin
          w_we        = 1'b1;
          w_wdata     = w_bitlen[63:32];
          w_wp_nxt    = w_wp_inc;
          w_state_nxt = ST_LEN_LO;
        end
      end

      ST_LEN_LO: begin
        if (w_full) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = ST_ERR;
        end else begin
          w_we             = 1'b1;
          w_wdata          = w_bitlen[31:0];
          w_wp_nxt         = w_wp_inc;
          w_msg_size_nxt   = w_bitlen;
          w_num_blocks_nxt = w_wp_inc[ADDR_W:4];
          w_state_nxt      = ST_START;
        end
      end

      ST_START: w_state_nxt = ST_WAIT;

      ST_WAIT: begin
        if (done) begin
          w_wp_nxt    = '0;
          w_bytes_nxt = '0;
          w_mark_nxt  = 1'b0;
          w_state_nxt = ST_LOAD;
        end
      end

      // ST_ERR swallows input and is left only through reset.
      default: w_state_nxt = r_state;
    endcase
  end

  sha256_word_buf #(
    .DEPTH  (c_depth),
    .ADDR_W (ADDR_W)
  ) u_buf (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (r_wp[ADDR_W-1:0]),
    .i_wdata (w_wdata),
    .i_raddr (rd_addr),
    .o_rdata (w)
  );

  assign in_ready   = !reset && ((r_state == ST_LOAD) || (r_state == ST_ERR));
  assign update     = (r_state == ST_START);
  assign busy       = (r_state != ST_LOAD);
  assign err        = r_err;
  assign msg_size   = r_msg_size;
  assign num_blocks = r_num_blocks;

endmodule
`default_nettype wire

// File: tb/tb_sha256_msg_loader.sv
`default_nettype none
// ============================================================================
// Module : tb_sha256_msg_loader
// Brief  : Randomised self-checking bench against a byte-level padding model.
// Rev    : 1.0
// ============================================================================
module tb_sha256_msg_loader;

  localparam int DEPTH = 32;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic [2:0]  in_nbytes = '0;
  logic        in_ready;
  logic [4:0]  rd_addr = '0;
  logic [31:0] w;
  logic [63:0] msg_size;
  logic [1:0]  num_blocks;
  logic        update;
  logic        done = 1'b0;
  logic        busy;
  logic        err;

  sha256_msg_loader #(.NUM_BLOCKS(2)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_nbytes(in_nbytes), .in_ready(in_ready),
    .rd_addr(rd_addr), .w(w), .msg_size(msg_size), .num_blocks(num_blocks),
    .update(update), .done(done), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int          g_vectors = 0;
  int          g_miscompares = 0;
  logic [7:0]  g_msg[$];
  logic [31:0] g_exp[64];
  int          g_exp_words;
  int          g_nw;
  int          g_exp_lat;
  bit          g_zero_tail;
  bit          g_stall;
  int          g_lat;
  int          g_pulses;
  logic [31:0] g_rd[DEPTH];

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Full SHA-256 over the words read back from the DUT buffer.
  function automatic logic [255:0] sha256_of(input int nblk);
    logic [31:0] h[8];
    logic [31:0] ws[64];
    logic [31:0] a, b, c, d, e, f, g, hh, t1, t2;
    h = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
          32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    for (int blk = 0; blk < nblk; blk++) begin
      for (int t = 0; t < 64; t++) begin
        if (t < 16) ws[t] = g_rd[blk*16 + t];
        else ws[t] = ws[t-16] + ws[t-7]
                   + (ror(ws[t-15], 7) ^ ror(ws[t-15], 18) ^ (ws[t-15] >> 3))
                   + (ror(ws[t-2], 17) ^ ror(ws[t-2], 19) ^ (ws[t-2] >> 10));
      end
      a = h[0]; b = h[1]; c = h[2]; d = h[3]; e = h[4]; f = h[5]; g = h[6]; hh = h[7];
      for (int t = 0; t < 64; t++) begin
        t1 = hh + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K[t] + ws[t];
        t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
        hh = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
      end
      h[0] += a; h[1] += b; h[2] += c; h[3] += d; h[4] += e; h[5] += f; h[6] += g; h[7] += hh;
    end
    return {h[0], h[1], h[2], h[3], h[4], h[5], h[6], h[7]};
  endfunction

  // Reference: standard SHA-256 padding on the byte string, plus spec latency.
  task automatic build_model();
    logic [7:0]  pb[$];
    logic [63:0] bitlen;
    int          len;
    bit          spill;
    len    = g_msg.size();
    pb     = g_msg;
    bitlen = 64'(len) * 8;
    pb.push_back(8'h80);
    while (pb.size() % 64 != 56) pb.push_back(8'h00);
    for (int i = 7; i >= 0; i--) pb.push_back(bitlen[8*i +: 8]);
    g_exp_words = pb.size() / 4;
    for (int i = 0; i < g_exp_words && i < 64; i++)
      g_exp[i] = {pb[4*i], pb[4*i+1], pb[4*i+2], pb[4*i+3]};
    g_nw      = (len % 4 == 0 && len > 0 && !g_zero_tail) ? len / 4 : len / 4 + 1;
    spill     = g_exp_words > 16 * ((g_nw + 15) / 16);
    g_exp_lat = 16 - ((g_nw - 1) % 16) + (spill ? 16 : 0);
  endtask

  task automatic drive_msg();
    int          len, nb_last, tries;
    logic [31:0] wd;
    len     = g_msg.size();
    nb_last = len - 4 * (g_nw - 1);
    g_stall = 0;
    for (int k = 0; k < g_nw; k++) begin
      repeat ($urandom_range(0, 2)) begin @(negedge clk); in_valid = 1'b0; end
      wd = $urandom;
      for (int j = 0; j < 4; j++)
        if (4*k + j < len) wd[31-8*j -: 8] = g_msg[4*k + j];
      @(negedge clk);
      in_valid  = 1'b1;
      in_data   = wd;
      in_last   = (k == g_nw - 1);
      in_nbytes = in_last ? 3'(nb_last) : 3'($urandom_range(0, 4));
      tries = 0;
      while (!in_ready && tries < 50) begin @(negedge clk); tries++; end
      if (!in_ready) g_stall = 1;
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_update();
    g_lat = -1;
    g_pulses = 0;
    for (int c = 1; c <= 48; c++) begin
      @(negedge clk);
      if (update === 1'b1) begin
        g_pulses++;
        if (g_lat < 0) g_lat = c;
      end
    end
  endtask

  task automatic read_buf(input int n);
    for (int i = 0; i < n && i < DEPTH; i++) begin
      rd_addr = 5'(i);
      #1;
      g_rd[i] = w;
    end
  endtask

  task automatic release_done();
    @(negedge clk); done = 1'b1;
    @(negedge clk); done = 1'b0;
  endtask

  task automatic load_string(input string s);
    g_msg.delete();
    for (int i = 0; i < s.len(); i++) g_msg.push_back(s[i]);
  endtask

  task automatic test_reset();
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    g_vectors++;
    if ({in_ready, update, busy, err} !== 4'b0000 || msg_size !== 64'd0 || num_blocks !== 2'd0) begin
      g_miscompares++;
      $display("FAIL reset_outputs: got rdy/upd/busy/err=%b size=%h nb=%0d required 0000/0/0",
               {in_ready, update, busy, err}, msg_size, num_blocks);
    end
    reset = 1'b0;
    #1;
    g_vectors++;
    if (in_ready !== 1'b1) begin
      g_miscompares++;
      $display("FAIL reset_release_ready: got %b required 1", in_ready);
    end
  endtask

  task automatic test_messages();
    logic [255:0] exp_h, got_h;
    int           len;
    for (int it = 0; it < 9; it++) begin
      g_zero_tail = 1'b0;
      if (it == 0) load_string("abc");
      else if (it == 1) g_msg.delete();
      else if (it == 2) load_string("abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq");
      else begin
        g_msg.delete();
        len = $urandom_range(0, 119);
        for (int i = 0; i < len; i++) g_msg.push_back(8'($urandom));
        g_zero_tail = 1'($urandom_range(0, 1));
      end
      build_model();
      drive_msg();
      wait_update();
      g_vectors++;
      if (g_stall) begin g_miscompares++; $display("FAIL accept msg%0d: in_ready stuck low, required 1", it); end
      g_vectors++;
      if (g_lat !== g_exp_lat) begin
        g_miscompares++; $display("FAIL latency msg%0d: got %0d required %0d", it, g_lat, g_exp_lat);
      end
      g_vectors++;
      if (g_pulses !== 1) begin
        g_miscompares++; $display("FAIL update_pulses msg%0d: got %0d required 1", it, g_pulses);
      end
      g_vectors++;
      if ({busy, in_ready, err} !== 3'b100) begin
        g_miscompares++; $display("FAIL wait_flags msg%0d: got %b required 100", it, {busy, in_ready, err});
      end
      read_buf(g_exp_words);
      for (int i = 0; i < g_exp_words; i++) begin
        g_vectors++;
        if (g_rd[i] !== g_exp[i]) begin
          g_miscompares++; $display("FAIL buf[%0d] msg%0d: got %h required %h", i, it, g_rd[i], g_exp[i]);
        end
      end
      g_vectors++;
      if (msg_size !== 64'(g_msg.size()) * 8) begin
        g_miscompares++; $display("FAIL msg_size msg%0d: got %0d required %0d", it, msg_size, g_msg.size() * 8);
      end
      g_vectors++;
      if (num_blocks !== 2'(g_exp_words / 16)) begin
        g_miscompares++; $display("FAIL num_blocks msg%0d: got %0d required %0d", it, num_blocks, g_exp_words / 16);
      end
      if (it < 3) begin
        case (it)
          0:       exp_h = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
          1:       exp_h = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
          default: exp_h = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;
        endcase
        got_h = sha256_of(g_exp_words / 16);
        g_vectors++;
        if (got_h !== exp_h) begin
          g_miscompares++; $display("FAIL hash msg%0d: got %h required %h", it, got_h, exp_h);
        end
      end
      release_done();
      g_vectors++;
      if ({busy, in_ready} !== 2'b01) begin
        g_miscompares++; $display("FAIL after_done msg%0d: got busy/rdy=%b required 01", it, {busy, in_ready});
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [255:0] got_h;
    load_string("abc");
    g_zero_tail = 1'b0;
    build_model();
    drive_msg();
    wait_update();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = $urandom; in_last = 1'($urandom_range(0, 1)); in_nbytes = 3'd4;
      g_vectors++;
      if (in_ready !== 1'b0) begin
        g_miscompares++; $display("FAIL wait_ready cycle%0d: got %b required 0", c, in_ready);
      end
    end
    @(negedge clk); in_valid = 1'b0; in_last = 1'b0;
    rd_addr = 5'd0; #1;
    g_vectors++;
    if (w !== 32'h61626380) begin
      g_miscompares++; $display("FAIL wait_buf_held: got %h required 61626380", w);
    end
    release_done();
    release_done();
    g_vectors++;
    if (busy !== 1'b0) begin
      g_miscompares++; $display("FAIL done_in_load: got busy %b required 0", busy);
    end
    drive_msg();
    wait_update();
    g_vectors++;
    if (g_lat !== 16 || g_pulses !== 1) begin
      g_miscompares++; $display("FAIL second_update: got lat %0d pulses %0d required 16 and 1", g_lat, g_pulses);
    end
    read_buf(16);
    got_h = sha256_of(1);
    g_vectors++;
    if (got_h !== 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad) begin
      g_miscompares++; $display("FAIL second_hash: got %h required ba7816bf...f20015ad", got_h);
    end
    g_vectors++;
    if (msg_size !== 64'd24 || num_blocks !== 2'd1) begin
      g_miscompares++; $display("FAIL second_size: got %0d/%0d required 24/1", msg_size, num_blocks);
    end
    release_done();
  endtask

  task automatic test_reset_mid_load();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = $urandom; in_last = 1'b0;
    end
    #2 reset = 1'b1;
    #1;
    g_vectors++;
    if ({in_ready, update, busy, err} !== 4'b0000 || msg_size !== 64'd0 || num_blocks !== 2'd0) begin
      g_miscompares++;
      $display("FAIL async_reset: got rdy/upd/busy/err=%b size=%0d nb=%0d required 0000/0/0",
               {in_ready, update, busy, err}, msg_size, num_blocks);
    end
    @(negedge clk); in_valid = 1'b0; reset = 1'b0;
    load_string("abc");
    g_zero_tail = 1'b0;
    build_model();
    drive_msg();
    wait_update();
    read_buf(16);
    for (int i = 0; i < 16; i++) begin
      g_vectors++;
      if (g_rd[i] !== g_exp[i]) begin
        g_miscompares++; $display("FAIL post_reset_buf[%0d]: got %h required %h", i, g_rd[i], g_exp[i]);
      end
    end
    g_vectors++;
    if (msg_size !== 64'd24 || g_pulses !== 1) begin
      g_miscompares++; $display("FAIL post_reset_size: got %0d pulses %0d required 24 and 1", msg_size, g_pulses);
    end
    release_done();
  endtask

  task automatic test_overflow();
    g_msg.delete();
    for (int i = 0; i < 120; i++) g_msg.push_back(8'($urandom));
    g_zero_tail = 1'b0;
    build_model();
    drive_msg();
    wait_update();
    g_vectors++;
    if (g_pulses !== 0) begin
      g_miscompares++; $display("FAIL overflow_update: got %0d pulses required 0", g_pulses);
    end
    g_vectors++;
    if ({err, in_ready, busy} !== 3'b111) begin
      g_miscompares++; $display("FAIL overflow_flags: got err/rdy/busy=%b required 111", {err, in_ready, busy});
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = ~g_exp[0]; in_last = 1'b1; in_nbytes = 3'd4;
      g_vectors++;
      if (in_ready !== 1'b1 || err !== 1'b1) begin
        g_miscompares++; $display("FAIL err_state cycle%0d: got rdy %b err %b required 1 1", c, in_ready, err);
      end
    end
    @(negedge clk); in_valid = 1'b0; in_last = 1'b0;
    rd_addr = 5'd0; #1;
    g_vectors++;
    if (w !== g_exp[0]) begin
      g_miscompares++; $display("FAIL err_drops_input: got %h required %h", w, g_exp[0]);
    end
    @(negedge clk); reset = 1'b1; #1;
    g_vectors++;
    if (err !== 1'b0) begin
      g_miscompares++; $display("FAIL reset_clears_err: got %b required 0", err);
    end
    @(negedge clk); reset = 1'b0; #1;
    g_vectors++;
    if ({in_ready, busy} !== 2'b10) begin
      g_miscompares++; $display("FAIL after_err_reset: got rdy/busy=%b required 10", {in_ready, busy});
    end
  endtask

  initial begin
    test_reset();
    test_messages();
    test_back_to_back();
    test_reset_mid_load();
    test_overflow();
    $display("== %0d vectors applied, %0d miscompares ==", g_vectors, g_miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sha256_msg_loader.md
Name: sha256_msg_loader

Overview:
Host-side writer that feeds sha256_update. It accepts a message as a stream of 32-bit big-endian words and applies SHA-256 padding: 0x80 byte, zero fill, and 64-bit bit length. The padded blocks go into an internal word buffer that sha256_update reads by {cur_block, block_offset}. The block drives msg_size, then pulses update, and holds the buffer until sha256_update reports done.

Parameters:
NUM_BLOCKS, 2, buffer capacity in 512-bit blocks; buffer depth is 16*NUM_BLOCKS words.
ADDR_W, $clog2(16*NUM_BLOCKS), word address width (derived; do not override).

Ports:
clk  in  1  system clock, rising-edge.
reset  in  1  asynchronous, active-high.
in_data  in  32  message word, first byte in bits [31:24].
in_valid  in  1  in_data valid.
in_last  in  1  final word of message; qualified by in_valid.
in_nbytes  in  3  valid bytes in the final word, 0..4; ignored unless in_last.
in_ready  out  1  word accepted on a cycle with in_valid && in_ready.
rd_addr  in  ADDR_W  read word address, {cur_block, block_offset} truncated.
w  out  32  buffer[rd_addr], combinational read.
msg_size  out  64  message length in bits.
num_blocks  out  ADDR_W-3  number of padded blocks written.
update  out  1  one-cycle start pulse to sha256_update.
done  in  1  sha256_update finished; releases the buffer.
busy  out  1  high in any state other than LOAD.
err  out  1  sticky overflow flag.

Behaviour:
- Reset values: in_ready=0 during reset, then 1 in LOAD. update=0, busy=0, err=0, msg_size=0, num_blocks=0, write pointer=0. Buffer contents are not cleared.
- States: LOAD, PAD, LEN_HI, LEN_LO, START, WAIT, ERR.
- LOAD: in_ready=1. Each accepted word is written to buf[wp]; wp increments and the byte count increases by 4.
- Accepted word with in_last:
  - Byte count increases by in_nbytes.
  - If in_nbytes<4: the stored word keeps the first in_nbytes bytes, then byte 0x80, then zeros (in_nbytes=0 stores 0x80000000). Go to PAD with the marker already placed.
  - If in_nbytes==4: the word is stored as-is. Go to PAD with the marker still pending.
- PAD: one word per cycle.
  - First word is 0x80000000 if the marker is pending, otherwise 0x00000000.
  - Continue until wp[3:0]==14 with the marker placed, then go to LEN_HI.
- LEN_HI / LEN_LO: write bytes*8 as high word, then low word. msg_size updates in LEN_LO. num_blocks = (wp+1)/16.
- START: update=1 for exactly one cycle, then WAIT.
- WAIT: busy=1, in_ready=0. On done=1, go to LOAD, reset wp and byte count, keep msg_size and num_blocks.
- Latency: update is asserted (16 - (last_wp mod 16)) cycles after the last-word handshake, or 16 more cycles if padding spills into a new block.
- Overflow: any write at wp==16*NUM_BLOCKS sets err and enters ERR.
  - ERR: in_ready=1, input is dropped, no update.
  - ERR exits only on reset.
- done outside WAIT is ignored. in_valid outside LOAD/ERR is not accepted.
- Reset mid-operation aborts immediately to the reset values. A pending update is never issued.
- w reflects writes on the cycle after the write edge.

Decomposition:
- Shared package/header (sha256types.vh): `WORD macro, SHA256_BLOCK_WORDS=16, SHA256_LEN_WORD_HI=14, pad marker constant 32'h80000000.
- One sub-module, sha256_word_buf: 16*NUM_BLOCKS x 32 RAM with one synchronous write port and one asynchronous read port.
- The FSM and pad logic stay in the top module.

Test Plan:
- "abc" as one word 0x61626300, in_last, nbytes=3 -> buf[0]=0x61626380, buf[1..14]=0, buf[15]=0x18, msg_size=24, num_blocks=1, single update pulse.
- Empty message: in_last with nbytes=0 -> buf[0]=0x80000000, buf[1..15]=0, msg_size=0, num_blocks=1.
- 56-byte message (14 words, last nbytes=4) -> buf[14]=0x80000000, buf[15..29]=0, buf[31]=0x1C0, num_blocks=2. Run through sha256_update; hash matches the reference vector.
- Back-to-back messages: drive in_valid while in WAIT -> in_ready=0, nothing accepted. After done, second message "abc" loads from wp=0 and hashes correctly.
- NUM_BLOCKS=2 with 120 bytes (30 words, nbytes=4; padding needs block 3) -> err=1, update never pulses, in_ready=1 in ERR. Reset clears err.
- Reset asserted mid-LOAD at word 5 -> outputs return to reset values asynchronously. A following "abc" produces the correct buffer and msg_size=24.
